// File: rtl/sum_fact_pkg.sv
// Shared definitions for the sum_fact_param factorial engine.
// Contents:
//   - default operand and datapath widths;
//   - mode encodings;
//   - the controller state type.
package sum_fact_pkg;

    localparam int unsigned NW_DEFAULT = 4;
    localparam int unsigned SW_DEFAULT = 32;

    localparam logic MODE_SUM  = 1'b0;
    localparam logic MODE_FACT = 1'b1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/sum_fact_sat_mac.sv
// Combinational step of the factorial engine. It forms fact*k and adds that
// product to the running sum, saturating both values to all-ones on overflow.
//
// Ports:
//   fact_i  - current factorial value
//   k_i     - current multiplier (iteration counter)
//   sum_i   - current running sum
//   fact_o  - saturated fact*k
//   sum_o   - saturated sum + fact_o
//   ovf_o   - high when either the product or the sum saturated this step
module sum_fact_sat_mac #(
    parameter int unsigned NW = 4,
    parameter int unsigned SW = 32
) (
    input  logic [SW-1:0] fact_i,
    input  logic [NW-1:0] k_i,
    input  logic [SW-1:0] sum_i,
    output logic [SW-1:0] fact_o,
    output logic [SW-1:0] sum_o,
    output logic          ovf_o
);

    logic [SW+NW-1:0] prod;
    logic             prod_ovf;
    logic [SW:0]      sum_wide;
    logic             sum_ovf;

    always_comb begin
        prod     = {{NW{1'b0}}, fact_i} * {{SW{1'b0}}, k_i};
        prod_ovf = |prod[SW+NW-1:SW];
        fact_o   = prod_ovf ? {SW{1'b1}} : prod[SW-1:0];

        // The sum adds the already-saturated product, so a saturated term
        // forces the sum to saturate as well.
        sum_wide = {1'b0, sum_i} + {1'b0, fact_o};
        sum_ovf  = sum_wide[SW];
        sum_o    = sum_ovf ? {SW{1'b1}} : sum_wide[SW-1:0];

        ovf_o    = prod_ovf | sum_ovf;
    end

endmodule

// File: rtl/sum_fact_param.sv
// Sequential factorial engine. For an operand N it produces either the sum
// 0!+1!+...+N! (mode 0) or N! alone (mode 1), one multiply-add per cycle,
// with saturation and a sticky overflow flag.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous, active-high reset
//   n_in       - operand N, captured on accept
//   mode_in    - 0: sum of factorials, 1: N! only; captured on accept
//   in_valid   - request valid
//   in_ready   - high in IDLE only
//   result     - final value while out_valid, otherwise 0
//   ovf        - result saturated; meaningful only while out_valid, else 0
//   out_valid  - high in DONE only
//   out_ack    - consumer takes the result
module sum_fact_param
    import sum_fact_pkg::*;
#(
    parameter int unsigned NW = NW_DEFAULT,
    parameter int unsigned SW = SW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [NW-1:0] n_in,
    input  logic          mode_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [SW-1:0] result,
    output logic          ovf,
    output logic          out_valid,
    input  logic          out_ack
);

    state_e        state_q, state_d;
    logic [NW-1:0] n_q, n_d;
    logic [NW-1:0] k_q, k_d;
    logic          mode_q, mode_d;
    logic [SW-1:0] fact_q, fact_d;
    logic [SW-1:0] sum_q, sum_d;
    logic          ovf_q, ovf_d;

    logic [SW-1:0] mac_fact;
    logic [SW-1:0] mac_sum;
    logic          mac_ovf;

    sum_fact_sat_mac #(
        .NW (NW),
        .SW (SW)
    ) u_mac (
        .fact_i (fact_q),
        .k_i    (k_q),
        .sum_i  (sum_q),
        .fact_o (mac_fact),
        .sum_o  (mac_sum),
        .ovf_o  (mac_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            n_q     <= '0;
            k_q     <= '0;
            mode_q  <= MODE_SUM;
            fact_q  <= SW'(1);
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            fact_q  <= fact_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        mode_d  = mode_q;
        fact_d  = fact_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    n_d     = n_in;
                    mode_d  = mode_in;
                    k_d     = NW'(1);
                    fact_d  = SW'(1);
                    // Sum starts at 1 to account for the 0! term.
                    sum_d   = SW'(1);
                    ovf_d   = 1'b0;
                    state_d = (n_in == '0) ? StDone : StBusy;
                end
            end
            StBusy: begin
                fact_d = mac_fact;
                sum_d  = mac_sum;
                ovf_d  = ovf_q | mac_ovf;
                // Holding k at n on the last step keeps n = 2^NW-1 from wrapping.
                if (k_q == n_q) begin
                    state_d = StDone;
                end else begin
                    k_d = k_q + NW'(1);
                end
            end
            StDone: begin
                if (out_ack) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        result    = '0;
        ovf       = 1'b0;
        if (state_q == StDone) begin
            result = (mode_q == MODE_FACT) ? fact_q : sum_q;
            ovf    = ovf_q;
        end
    end

endmodule

// File: tb/tb_sum_fact_param.sv
// Self-checking bench for sum_fact_param. Two instances (SW=32 and SW=16)
// share one stimulus stream; each is compared with an exact-arithmetic model.
module tb_sum_fact_param;

    localparam int unsigned NW  = 4;
    localparam int unsigned SWA = 32;
    localparam int unsigned SWB = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [NW-1:0]  n_in;
    logic           mode_in;
    logic           in_valid;
    logic           out_ack;

    logic           in_ready_a, out_valid_a, ovf_a;
    logic [SWA-1:0] result_a;
    logic           in_ready_b, out_valid_b, ovf_b;
    logic [SWB-1:0] result_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sum_fact_param #(
        .NW (NW),
        .SW (SWA)
    ) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .n_in      (n_in),
        .mode_in   (mode_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .result    (result_a),
        .ovf       (ovf_a),
        .out_valid (out_valid_a),
        .out_ack   (out_ack)
    );

    sum_fact_param #(
        .NW (NW),
        .SW (SWB)
    ) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .n_in      (n_in),
        .mode_in   (mode_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .result    (result_b),
        .ovf       (ovf_b),
        .out_valid (out_valid_b),
        .out_ack   (out_ack)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Exact factorials in 64 bits (15! fits), then clamp to the datapath width.
    // The running sum always dominates N!, so overflow happens iff it exceeds max.
    function automatic void model(input int n, input bit mode, input int sw,
                                  output logic [63:0] res, output bit ovf_exp);
        longint unsigned f;
        longint unsigned s;
        longint unsigned maxv;
        f = 1;
        s = 1;
        for (int i = 1; i <= n; i++) begin
            f = f * longint'(i);
            s = s + f;
        end
        maxv    = (64'd1 << sw) - 64'd1;
        ovf_exp = (s > maxv);
        if (mode) res = (f > maxv) ? maxv : f;
        else      res = (s > maxv) ? maxv : s;
    endfunction

    // Issue one request, wait for the result, check it, hold for hold_cyc
    // cycles (pulsing in_valid) and acknowledge. With noise set, in_valid,
    // n_in, mode_in and out_ack toggle randomly while the engine is busy.
    task automatic run_req(input int n, input bit mode, input bit noise, input int hold_cyc);
        logic [63:0] exp_a, exp_b;
        bit          eo_a, eo_b;
        int          cyc;
        model(n, mode, SWA, exp_a, eo_a);
        model(n, mode, SWB, exp_b, eo_b);

        check_eq("in_ready_idle_a", 64'(in_ready_a), 64'd1);
        check_eq("in_ready_idle_b", 64'(in_ready_b), 64'd1);
        n_in     = NW'(n);
        mode_in  = mode;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // Edges after the accept edge until out_valid: N (zero for N=0).
        cyc = 0;
        while (!out_valid_a && cyc < 40) begin
            if (noise) begin
                in_valid = 1'($urandom);
                n_in     = NW'($urandom);
                mode_in  = 1'($urandom);
                out_ack  = 1'($urandom);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ack  = 1'b0;
        check_eq($sformatf("latency_n%0d", n), 64'(cyc), 64'(n));
        check_eq($sformatf("out_valid_b_n%0d", n), 64'(out_valid_b), 64'd1);
        check_eq($sformatf("result_a_n%0d_m%0d", n, mode), 64'(result_a), exp_a);
        check_eq($sformatf("ovf_a_n%0d_m%0d", n, mode), 64'(ovf_a), 64'(eo_a));
        check_eq($sformatf("result_b_n%0d_m%0d", n, mode), 64'(result_b), exp_b);
        check_eq($sformatf("ovf_b_n%0d_m%0d", n, mode), 64'(ovf_b), 64'(eo_b));

        for (int h = 0; h < hold_cyc; h++) begin
            in_valid = 1'(h % 2 == 0);
            n_in     = NW'($urandom);
            @(posedge clk);
            #1;
            check_eq("hold_result_a", 64'(result_a), exp_a);
            check_eq("hold_out_valid", 64'(out_valid_a), 64'd1);
            check_eq("hold_in_ready", 64'(in_ready_a), 64'd0);
        end
        in_valid = 1'b0;

        out_ack = 1'b1;
        @(posedge clk);
        #1;
        out_ack = 1'b0;
        check_eq("ack_in_ready", 64'(in_ready_a), 64'd1);
        check_eq("ack_out_valid", 64'(out_valid_a), 64'd0);
        check_eq("ack_result", 64'(result_a), 64'd0);
    endtask

    initial begin
        reset    = 1'b1;
        n_in     = '0;
        mode_in  = 1'b0;
        in_valid = 1'b0;
        out_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready_a), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid_a), 64'd0);
        check_eq("rst_result", 64'(result_a), 64'd0);
        check_eq("rst_ovf", 64'(ovf_a), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_req(3, 1'b0, 1'b0, 0);
        run_req(7, 1'b0, 1'b0, 0);
        run_req(5, 1'b1, 1'b0, 0);
        run_req(0, 1'b0, 1'b0, 0);
        run_req(0, 1'b1, 1'b0, 0);
        run_req(9, 1'b1, 1'b0, 0);
        run_req(4, 1'b1, 1'b0, 0);
        run_req(15, 1'b0, 1'b0, 0);
        run_req(15, 1'b1, 1'b0, 0);
        run_req(8, 1'b0, 1'b0, 5);

        // Reset in the middle of a busy request, between clock edges.
        n_in     = NW'(6);
        mode_in  = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("midrst_in_ready", 64'(in_ready_a), 64'd1);
        check_eq("midrst_out_valid", 64'(out_valid_a), 64'd0);
        check_eq("midrst_result", 64'(result_a), 64'd0);
        check_eq("midrst_ovf", 64'(ovf_a), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_req(2, 1'b0, 1'b0, 0);

        for (int i = 0; i < 25; i++) begin
            run_req(int'($urandom_range(0, 15)), 1'($urandom), 1'b1,
                    int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
